// File: rtl/memshare_pkg.sv
// Shared memShare scheduler definitions: bank-count defaults and the
// occupancy encoding used by the request-buffering blocks.
package memshare_pkg;

  localparam int ONEHOT_CODE_LEN_DEF = 4;
  localparam int BIN_CODE_LEN_DEF    = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_state_e;

endpackage : memshare_pkg

// File: rtl/memShare_bin2onehot.sv
// Binary bank index to one-hot bank select; inverse of the memShare
// onehot-to-binary converter for every in-range index.
module memShare_bin2onehot #(
  parameter int ONEHOT_CODE_LEN = memshare_pkg::ONEHOT_CODE_LEN_DEF,
  parameter int BIN_CODE_LEN    = memshare_pkg::BIN_CODE_LEN_DEF
) (
  input  logic [BIN_CODE_LEN-1:0]    bin_i,
  output logic [ONEHOT_CODE_LEN-1:0] onehot_o
);

  // Out-of-range indices decode to all-zero rather than aliasing a bank.
  always_comb begin
    // NOTE: default assigned first so no path through this block can infer a latch.
    onehot_o = '0;
    for (int i = 0; i < ONEHOT_CODE_LEN; i++) begin
      if (bin_i == BIN_CODE_LEN'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule : memShare_bin2onehot

// File: rtl/memshare_bin2onehot_dispatch.sv
// Two-entry request buffer that turns binary bank indices into one-hot bank
// selects for the shared column-bank arbiter, dropping out-of-range indices.
module memshare_bin2onehot_dispatch
  import memshare_pkg::*;
#(
  parameter int ONEHOT_CODE_LEN = ONEHOT_CODE_LEN_DEF,
  parameter int BIN_CODE_LEN    = BIN_CODE_LEN_DEF,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [BIN_CODE_LEN-1:0]    bin_i,
  input  logic                       bin_valid_i,
  output logic                       bin_ready_o,
  output logic [ONEHOT_CODE_LEN-1:0] onehot_o,
  output logic                       onehot_valid_o,
  input  logic                       onehot_ready_i,
  output logic                       range_err_o,
  output logic [CNT_WIDTH-1:0]       rqst_cnt_o
);

  localparam logic [BIN_CODE_LEN:0] NUM_BANKS = (BIN_CODE_LEN + 1)'(ONEHOT_CODE_LEN);

  occ_state_e                  state_q, state_d;
  logic [BIN_CODE_LEN-1:0]     mem_q [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic                        range_err_q;
  logic [CNT_WIDTH-1:0]        cnt_q;

  logic                        push, pop, in_range, store;
  logic [ONEHOT_CODE_LEN-1:0]  head_onehot;

  // Ready and valid come only from the registered state, so there is no
  // combinational path from onehot_ready_i back to bin_ready_o.
  assign bin_ready_o    = (state_q != OCC_FULL);
  assign onehot_valid_o = (state_q != OCC_EMPTY);

  assign push     = bin_valid_i && bin_ready_o;
  assign pop      = onehot_valid_o && onehot_ready_i;
  assign in_range = ({1'b0, bin_i} < NUM_BANKS);
  assign store    = push && in_range;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (store) state_d = OCC_ONE;
      OCC_ONE: begin
        if (store && !pop)      state_d = OCC_FULL;
        else if (pop && !store) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      range_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      range_err_q <= push && !in_range;
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: entry storage has no reset; the occupancy state alone says which entries are live.
  always_ff @(posedge sys_clk) begin
    if (store) mem_q[wr_ptr_q] <= bin_i;
  end

  memShare_bin2onehot #(
    .ONEHOT_CODE_LEN (ONEHOT_CODE_LEN),
    .BIN_CODE_LEN    (BIN_CODE_LEN)
  ) u_bin2onehot (
    .bin_i    (mem_q[rd_ptr_q]),
    .onehot_o (head_onehot)
  );

  assign onehot_o    = onehot_valid_o ? head_onehot : '0;
  assign range_err_o = range_err_q;
  assign rqst_cnt_o  = cnt_q;

endmodule : memshare_bin2onehot_dispatch

// File: doc/memshare_bin2onehot_dispatch.md
MEMSHARE_BIN2ONEHOT_DISPATCH -- requirements
Module: memshare_bin2onehot_dispatch

Interface
REQ-001 The block SHALL have parameter ONEHOT_CODE_LEN, default 4, the number of shared column-bank memories/IB-LUTs and the width of the one-hot select.
REQ-002 The block SHALL have parameter BIN_CODE_LEN, default 2, the width of the binary bank index; ceil(log2(ONEHOT_CODE_LEN)) <= BIN_CODE_LEN SHALL hold.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the dispatched-request counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be as follows; clock and reset are listed first.
- sys_clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- bin_i  in  BIN_CODE_LEN  binary bank index of the incoming request
- bin_valid_i  in  1  bin_i is valid
- bin_ready_o  out  1  block can accept a request
- onehot_o  out  ONEHOT_CODE_LEN  one-hot bank select of the head request; all-zero when no request is held
- onehot_valid_o  out  1  onehot_o holds a request
- onehot_ready_i  in  1  downstream bank arbiter consumes onehot_o
- range_err_o  out  1  one-cycle pulse: an out-of-range index was accepted and dropped
- rqst_cnt_o  out  CNT_WIDTH  count of requests delivered downstream

Function
REQ-006 A push SHALL occur on a rising edge where bin_valid_i && bin_ready_o; a pop SHALL occur on a rising edge where onehot_valid_o && onehot_ready_i.
REQ-007 Buffering SHALL be a 2-entry FIFO with occupancy state machine EMPTY, ONE, FULL.
- EMPTY --push--> ONE
- ONE --push only--> FULL
- ONE --pop only--> EMPTY
- ONE --push and pop--> ONE
- FULL --pop--> ONE
- All other cases hold the current state.
REQ-008 bin_ready_o SHALL be 1 in EMPTY and ONE and 0 in FULL, derived only from registered state with no combinational path from onehot_ready_i.
REQ-009 onehot_valid_o SHALL be 1 in ONE and FULL.
REQ-010 onehot_o SHALL equal (1 << head index) when onehot_valid_o = 1, and all-zero otherwise.
REQ-011 Latency SHALL be exactly one cycle: a request pushed at edge N is visible on onehot_o after edge N. There SHALL be no same-cycle bypass, including in EMPTY.
REQ-012 Requests SHALL be delivered in acceptance order.
REQ-013 onehot_o and onehot_valid_o SHALL hold stable while onehot_valid_o = 1 and onehot_ready_i = 0.
REQ-014 An accepted bin_i >= ONEHOT_CODE_LEN SHALL NOT be stored and SHALL NOT change the occupancy state.
- range_err_o SHALL be 1 for exactly the cycle after that edge.
- bin_ready_o SHALL be unaffected.
REQ-015 A simultaneous pop and out-of-range push SHALL be treated as a pop only.
REQ-016 rqst_cnt_o SHALL increment by 1 on every pop and wrap from 2^CNT_WIDTH-1 to 0.
REQ-017 In FULL, a push SHALL be impossible because bin_ready_o = 0; bin_valid_i asserted in FULL SHALL be ignored with no state change.

Reset
REQ-018 While rst = 1 at a rising edge, the block SHALL enter EMPTY, and the following outputs SHALL be 0 after that edge:
- onehot_o = 0
- onehot_valid_o = 0
- range_err_o = 0
- rqst_cnt_o = 0
REQ-019 bin_ready_o SHALL be 1 after that edge, and the block SHALL NOT perform any push or pop on that edge.
REQ-020 Reset asserted mid-operation SHALL discard all buffered requests; no stale request SHALL appear after reset deasserts.

Structure
REQ-021 ONEHOT_CODE_LEN and BIN_CODE_LEN defaults, together with the EMPTY/ONE/FULL state encodings, SHALL reside in the shared memShare package/include file used by the memShare scheduler blocks.
REQ-022 The index-to-one-hot conversion SHALL be a separate combinational sub-module memShare_bin2onehot (ports bin_i, onehot_o), instantiated once on the FIFO head.
REQ-023 For any in-range value, memShare_bin2onehot SHALL be the exact inverse of the existing onehot-to-binary converter.

Verification
REQ-024 Scenario 1: reset, then push bin_i=2 with onehot_ready_i=0 -> next cycle onehot_o=4'b0100, onehot_valid_o=1, rqst_cnt_o=0; the outputs hold for 5 cycles.
REQ-025 Scenario 2: push 3 then 1 with onehot_ready_i=0 -> state FULL and bin_ready_o=0; then assert onehot_ready_i -> outputs 4'b1000 then 4'b0010, then onehot_valid_o=0 and rqst_cnt_o=2.
REQ-026 Scenario 3: ONEHOT_CODE_LEN=3, BIN_CODE_LEN=2, push bin_i=3 -> range_err_o=1 for one cycle, onehot_valid_o stays 0, rqst_cnt_o unchanged.
REQ-027 Scenario 4: hold bin_valid_i=1 and onehot_ready_i=1 streaming 0,1,2,3 repeatedly for 20 cycles -> state stays ONE, one request is delivered per cycle in order, and rqst_cnt_o increments every cycle.
REQ-028 Scenario 5: buffer 2 entries, then assert rst for one cycle -> onehot_valid_o=0, onehot_o=0, bin_ready_o=1, rqst_cnt_o=0, and no stale output after release.
REQ-029 Scenario 6: preload the counter to 16'hFFFF via 65535 pops, then perform one more pop -> rqst_cnt_o=16'h0000.
